mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 28, meaning memory line address width.
REQ-002 The block SHALL have parameter DATA_W, default 128, meaning memory line data width.
REQ-003 The block SHALL have parameter D_PRIORITY, default 0: 0 = round-robin on contention, 1 = D-side always wins contention.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have ports i_read and i_write, input, 1 bit each: I-cache memory request.
REQ-007 The block SHALL have port i_addr, input, ADDR_W bits: I-cache request address.
REQ-008 The block SHALL have port i_wdata, input, DATA_W bits: I-cache write data.
REQ-009 The block SHALL have port i_rdata, output, DATA_W bits: I-cache read data.
REQ-010 The block SHALL have port i_ready, output, 1 bit: I-cache request complete.
REQ-011 The block SHALL have ports d_read and d_write, input, 1 bit each: D-cache memory request.
REQ-012 The block SHALL have port d_addr, input, ADDR_W bits: D-cache request address.
REQ-013 The block SHALL have port d_wdata, input, DATA_W bits: D-cache write data.
REQ-014 The block SHALL have port d_rdata, output, DATA_W bits: D-cache read data.
REQ-015 The block SHALL have port d_ready, output, 1 bit: D-cache request complete.
REQ-016 The block SHALL have ports mem_read and mem_write, output, 1 bit each: shared memory request.
REQ-017 The block SHALL have port mem_addr, output, ADDR_W bits: shared memory address.
REQ-018 The block SHALL have port mem_wdata, output, DATA_W bits: shared memory write data.
REQ-019 The block SHALL have port mem_rdata, input, DATA_W bits: shared memory read data.
REQ-020 The block SHALL have port mem_ready, input, 1 bit: single-cycle completion pulse from memory.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, I_BUSY and D_BUSY.
REQ-022 In IDLE, a requester SHALL count as requesting when its read or write input is high; with only one requester active, that requester SHALL be granted at the next edge.
REQ-023 Under contention with D_PRIORITY=1, D SHALL be granted.
REQ-024 Under contention with D_PRIORITY=0, the requester not recorded in last_grant SHALL be granted; last_grant SHALL update on every grant.
REQ-025 On grant, the block SHALL latch op, addr and wdata of the winner into registers; mem_read, mem_write, mem_addr and mem_wdata SHALL be driven only from these registers.
REQ-026 Latency: a request sampled in IDLE at edge t SHALL appear on mem_read/mem_write in cycle t+1.
REQ-027 mem_read/mem_write SHALL be held with constant address and data until the cycle mem_ready is high.
REQ-028 If a requester asserts read and write together, the block SHALL issue a write only.
REQ-029 In the mem_ready cycle, the granted requester's ready SHALL be high combinationally and its rdata SHALL equal mem_rdata; the other requester's ready SHALL stay 0.
REQ-030 i_rdata and d_rdata SHALL be 0 whenever the corresponding ready is 0.
REQ-031 On the edge ending the mem_ready cycle, the FSM SHALL return to IDLE and deassert mem_read/mem_write.
REQ-032 Minimum spacing: a request arriving in the IDLE cycle right after completion SHALL reach memory one cycle later; no back-to-back bus cycles.
REQ-033 Requester contract: requesters SHALL drop their request in the cycle after their ready; a request still high at that point SHALL be treated as a new request.
REQ-034 Requests from either side SHALL be ignored while BUSY.
REQ-035 A grantee dropping its request mid-transaction SHALL NOT abort the transaction; the arbiter SHALL wait for mem_ready.
REQ-036 mem_ready while in IDLE SHALL be ignored; no ready output SHALL pulse.
REQ-037 With D_PRIORITY=0, neither requester SHALL wait for more than one transaction of the other under continuous contention.

Reset
REQ-038 While rst_n is low at an edge: state = IDLE, last_grant = I, latched op/addr/wdata = 0, and mem_read, mem_write, mem_addr and mem_wdata = 0.
REQ-039 Reset mid-transaction SHALL abandon the transaction; no ready SHALL be asserted for it.
REQ-040 Reset SHALL take priority over mem_ready in the same cycle.

Verification
REQ-041 I-only read of addr 0x0000010, mem_ready 3 cycles after issue -> mem_read high for 3 cycles with mem_addr 0x0000010; i_ready for 1 cycle with i_rdata = mem_rdata; d_ready stays 0.
REQ-042 With D_PRIORITY=0 after reset, i_read and d_write asserted together in IDLE -> D served first (last_grant=I), then I; the next contention goes to D.
REQ-043 With D_PRIORITY=1, I and D requesting continuously -> D wins every contention.
REQ-044 D write with d_wdata changing after grant -> mem_wdata holds the value latched at grant until mem_ready.
REQ-045 rst_n low during D_BUSY, then mem_ready arrives -> no d_ready; mem_write 0 in the cycle after reset; FSM in IDLE.
REQ-046 mem_ready pulsed while in IDLE -> i_ready = d_ready = 0; state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between an I-cache and a D-cache.
// One transaction in flight at a time; the winner's request is latched at grant
// and held on the memory bus until the memory returns its completion pulse.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned D_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache side
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // Shared memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                last_d_q;   // 1 = D was granted most recently, 0 = I
  logic                grant_i;
  logic                grant_d;
  logic                i_req;
  logic                d_req;
  logic                op_read_q;
  logic                op_write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // State register and round-robin history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        last_d_q <= 1'b1;
      end else if (grant_i) begin
        last_d_q <= 1'b0;
      end
    end
  end

  // Next-state and grant selection; requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          // Under round-robin, the side not granted last time wins
          if ((D_PRIORITY != 0) || !last_d_q) begin
            grant_d = 1'b1;
          end else begin
            grant_i = 1'b1;
          end
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_d) begin
          state_d = D_BUSY;
        end else if (grant_i) begin
          state_d = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's request at grant; clear the bus strobes on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (grant_i) begin
      op_write_q <= i_write;
      op_read_q  <= i_read & ~i_write;
      addr_q     <= i_addr;
      wdata_q    <= i_wdata;
    end else if (grant_d) begin
      op_write_q <= d_write;
      op_read_q  <= d_read & ~d_write;
      addr_q     <= d_addr;
      wdata_q    <= d_wdata;
    end else if ((state_q != IDLE) && mem_ready) begin
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
    end
  end

  assign mem_read  = op_read_q;
  assign mem_write = op_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Completion steering; a pending reset suppresses the ready of the abandoned transaction
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    i_rdata = '0;
    d_rdata = '0;
    if (rst_n && mem_ready) begin
      if (state_q == I_BUSY) begin
        i_ready = 1'b1;
        i_rdata = mem_rdata;
      end else if (state_q == D_BUSY) begin
        d_ready = 1'b1;
        d_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin instance (u0) and one
// D-priority instance (u1) share stimulus; each task checks its own scenario.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;

  localparam logic [ADDR_W-1:0] IA1 = 28'h0000010;
  localparam logic [ADDR_W-1:0] IA2 = 28'h0000A40;
  localparam logic [ADDR_W-1:0] DA1 = 28'h1234560;
  localparam logic [ADDR_W-1:0] DA2 = 28'h0ABCDE0;
  localparam logic [ADDR_W-1:0] DA3 = 28'h0FFFFF0;
  localparam logic [DATA_W-1:0] W1  = 128'h11112222_33334444_55556666_77778888;
  localparam logic [DATA_W-1:0] W3  = 128'hDEADBEEF_00000001_CAFEF00D_00000002;
  localparam logic [DATA_W-1:0] W4  = 128'h0BADC0DE_FFFFFFFF_0BADC0DE_FFFFFFFF;
  localparam logic [DATA_W-1:0] R1  = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
  localparam logic [DATA_W-1:0] R2  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  logic              clk;
  logic              rst_n;
  logic              i_read, i_write, d_read, d_write;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] i_wdata, d_wdata, mem_rdata;
  logic              mem_ready;

  logic [DATA_W-1:0] i_rdata0, d_rdata0, mem_wdata0;
  logic              i_ready0, d_ready0, mem_read0, mem_write0;
  logic [ADDR_W-1:0] mem_addr0;
  logic [DATA_W-1:0] i_rdata1, d_rdata1, mem_wdata1;
  logic              i_ready1, d_ready1, mem_read1, mem_write1;
  logic [ADDR_W-1:0] mem_addr1;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .D_PRIORITY(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata0), .i_ready(i_ready0),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata0), .d_ready(d_ready0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .D_PRIORITY(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata1), .i_ready(i_ready1),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_ready(d_ready1),
    .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_read0, mem_write0, mem_read1, mem_write1} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b required 0000", {mem_read0, mem_write0, mem_read1, mem_write1});
    end
    checks++;
    if (mem_addr0 !== '0 || mem_wdata0 !== '0) begin
      errors++; $display("FAIL reset_bus: addr %h wdata %h required 0", mem_addr0, mem_wdata0);
    end
    checks++;
    if ({i_ready0, d_ready0, i_ready1, d_ready1} !== 4'b0) begin
      errors++; $display("FAIL reset_ready: got %b required 0000", {i_ready0, d_ready0, i_ready1, d_ready1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    i_read = 1'b1; i_addr = IA1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (mem_read0 !== 1'b1 || mem_write0 !== 1'b0 || mem_addr0 !== IA1 || i_ready0 !== 1'b0) begin
        errors++; $display("FAIL i_read_issue%0d: rd %b wr %b addr %h rdy %b required 1 0 %h 0", c, mem_read0, mem_write0, mem_addr0, i_ready0, IA1);
      end
    end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = R1;
    #1;
    checks++;
    if (mem_read0 !== 1'b1 || mem_addr0 !== IA1 || i_ready0 !== 1'b1 || i_rdata0 !== R1 || d_ready0 !== 1'b0) begin
      errors++; $display("FAIL i_read_done: rd %b addr %h i_rdy %b i_rdata %h d_rdy %b required 1 %h 1 %h 0", mem_read0, mem_addr0, i_ready0, i_rdata0, d_ready0, IA1, R1);
    end
    @(negedge clk);
    mem_ready = 1'b0; i_read = 1'b0;
    checks++;
    if (mem_read0 !== 1'b0 || i_ready0 !== 1'b0 || i_rdata0 !== '0) begin
      errors++; $display("FAIL i_read_after: rd %b rdy %b rdata %h required 0 0 0", mem_read0, i_ready0, i_rdata0);
    end
  endtask

  task automatic test_contention_rr();
    i_read = 1'b1; i_addr = IA2;
    d_write = 1'b1; d_addr = DA1; d_wdata = W1;
    @(negedge clk);
    checks++;
    if (mem_write0 !== 1'b1 || mem_read0 !== 1'b0 || mem_addr0 !== DA1 || mem_wdata0 !== W1) begin
      errors++; $display("FAIL rr_first_d: wr %b rd %b addr %h wdata %h required 1 0 %h %h", mem_write0, mem_read0, mem_addr0, mem_wdata0, DA1, W1);
    end
    checks++;
    if (mem_write1 !== 1'b1 || mem_addr1 !== DA1) begin
      errors++; $display("FAIL prio_first_d: wr %b addr %h required 1 %h", mem_write1, mem_addr1, DA1);
    end
    mem_ready = 1'b1; mem_rdata = R1;
    #1;
    checks++;
    if (d_ready0 !== 1'b1 || d_rdata0 !== R1 || i_ready0 !== 1'b0 || i_rdata0 !== '0) begin
      errors++; $display("FAIL rr_d_done: d_rdy %b d_rdata %h i_rdy %b i_rdata %h required 1 %h 0 0", d_ready0, d_rdata0, i_ready0, i_rdata0, R1);
    end
    @(negedge clk);
    mem_ready = 1'b0; d_write = 1'b0;
    checks++;
    if (mem_read0 !== 1'b0 || mem_write0 !== 1'b0) begin
      errors++; $display("FAIL rr_gap: rd %b wr %b required 0 0", mem_read0, mem_write0);
    end
    @(negedge clk);
    checks++;
    if (mem_read0 !== 1'b1 || mem_addr0 !== IA2) begin
      errors++; $display("FAIL rr_then_i: rd %b addr %h required 1 %h", mem_read0, mem_addr0, IA2);
    end
    mem_ready = 1'b1; mem_rdata = R2;
    #1;
    checks++;
    if (i_ready0 !== 1'b1 || i_rdata0 !== R2 || d_ready0 !== 1'b0 || d_rdata0 !== '0) begin
      errors++; $display("FAIL rr_i_done: i_rdy %b i_rdata %h d_rdy %b required 1 %h 0", i_ready0, i_rdata0, d_ready0, R2);
    end
    @(negedge clk);
    mem_ready = 1'b0; d_write = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_write0 !== 1'b1 || mem_read0 !== 1'b0 || mem_addr0 !== DA1) begin
      errors++; $display("FAIL rr_second_d: wr %b rd %b addr %h required 1 0 %h", mem_write0, mem_read0, mem_addr0, DA1);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; i_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic test_continuous_contention();
    i_read = 1'b1; i_addr = IA1;
    d_read = 1'b1; d_addr = DA2;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      checks++;
      if (mem_read1 !== 1'b1 || mem_addr1 !== DA2) begin
        errors++; $display("FAIL prio_round%0d: rd %b addr %h required 1 %h", r, mem_read1, mem_addr1, DA2);
      end
      checks++;
      if (mem_read0 !== 1'b1 || mem_addr0 !== ((r % 2 == 0) ? IA1 : DA2)) begin
        errors++; $display("FAIL rr_round%0d: rd %b addr %h required 1 %h", r, mem_read0, mem_addr0, (r % 2 == 0) ? IA1 : DA2);
      end
      mem_ready = 1'b1; mem_rdata = R1 ^ DATA_W'(r);
      #1;
      checks++;
      if (d_ready1 !== 1'b1 || d_rdata1 !== (R1 ^ DATA_W'(r)) || i_ready1 !== 1'b0) begin
        errors++; $display("FAIL prio_ready%0d: d_rdy %b d_rdata %h i_rdy %b required 1 %h 0", r, d_ready1, d_rdata1, i_ready1, R1 ^ DATA_W'(r));
      end
      @(negedge clk);
      mem_ready = 1'b0;
      checks++;
      if (mem_read1 !== 1'b0 || mem_read0 !== 1'b0) begin
        errors++; $display("FAIL contention_gap%0d: rd1 %b rd0 %b required 0 0", r, mem_read1, mem_read0);
      end
      if (r == 3) begin
        i_read = 1'b0; d_read = 1'b0;
      end
    end
  endtask

  task automatic test_write_hold();
    d_read = 1'b1; d_write = 1'b1; d_addr = DA2; d_wdata = W3;
    @(negedge clk);
    checks++;
    if (mem_write0 !== 1'b1 || mem_read0 !== 1'b0 || mem_wdata0 !== W3) begin
      errors++; $display("FAIL rw_is_write: wr %b rd %b wdata %h required 1 0 %h", mem_write0, mem_read0, mem_wdata0, W3);
    end
    d_wdata = W4; d_addr = DA3; d_read = 1'b0; d_write = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (mem_write0 !== 1'b1 || mem_wdata0 !== W3 || mem_addr0 !== DA2) begin
        errors++; $display("FAIL write_hold%0d: wr %b wdata %h addr %h required 1 %h %h", c, mem_write0, mem_wdata0, mem_addr0, W3, DA2);
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (d_ready0 !== 1'b1) begin
      errors++; $display("FAIL write_done: d_rdy %b required 1", d_ready0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if (mem_write0 !== 1'b0) begin
      errors++; $display("FAIL write_release: wr %b required 0", mem_write0);
    end
  endtask

  task automatic test_reset_mid();
    d_write = 1'b1; d_addr = DA1; d_wdata = W1;
    @(negedge clk);
    checks++;
    if (mem_write0 !== 1'b1) begin
      errors++; $display("FAIL rst_mid_issue: wr %b required 1", mem_write0);
    end
    d_write = 1'b0; rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if (d_ready0 !== 1'b0 || d_ready1 !== 1'b0) begin
      errors++; $display("FAIL rst_vs_ready: d_rdy0 %b d_rdy1 %b required 0 0", d_ready0, d_ready1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_write0 !== 1'b0 || mem_addr0 !== '0 || mem_wdata0 !== '0 || d_ready0 !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: wr %b addr %h wdata %h d_rdy %b required 0 0 0 0", mem_write0, mem_addr0, mem_wdata0, d_ready0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if (mem_write0 !== 1'b0 || mem_read0 !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle: wr %b rd %b required 0 0", mem_write0, mem_read0);
    end
  endtask

  task automatic test_idle_ready();
    mem_ready = 1'b1; mem_rdata = R2;
    #1;
    checks++;
    if ({i_ready0, d_ready0, i_ready1, d_ready1} !== 4'b0 || i_rdata0 !== '0 || d_rdata0 !== '0) begin
      errors++; $display("FAIL idle_ready: rdys %b i_rdata %h d_rdata %h required 0000 0 0", {i_ready0, d_ready0, i_ready1, d_ready1}, i_rdata0, d_rdata0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    i_write = 1'b1; i_addr = IA2; i_wdata = W4;
    @(negedge clk);
    checks++;
    if (mem_write0 !== 1'b1 || mem_addr0 !== IA2 || mem_wdata0 !== W4) begin
      errors++; $display("FAIL idle_then_i: wr %b addr %h wdata %h required 1 %h %h", mem_write0, mem_addr0, mem_wdata0, IA2, W4);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (i_ready0 !== 1'b1 || d_ready0 !== 1'b0) begin
      errors++; $display("FAIL idle_then_i_done: i_rdy %b d_rdy %b required 1 0", i_ready0, d_ready0);
    end
    @(negedge clk);
    mem_ready = 1'b0; i_write = 1'b0;
    checks++;
    if (mem_write0 !== 1'b0) begin
      errors++; $display("FAIL idle_then_i_release: wr %b required 0", mem_write0);
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_reset();
    test_contention_rr();
    test_continuous_contention();
    test_write_hold();
    test_reset_mid();
    test_idle_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
